axis_frame_buffer: RTL and testbench
====================================

Name: axis_frame_buffer

Overview:
- Captures one AXI-Stream frame of up to DEPTH words into internal storage, then drains it word-by-word on a pull (`read`) interface.
- Successor to the fixed 4-word stream-to-FIFO capture block. It adds:
  - parametrised width and depth
  - a real valid/ready handshake
  - captured frame length
  - overflow handling
  - a runtime-selectable natural or bit-reversed drain order
- Sits between the bit-reversal datapath's AXI-Stream result port and the host-side FIFO reader.

Parameters:
- DATA_WIDTH, 32: width of stream and output words.
- DEPTH, 16: maximum frame length in words. Must be a power of two, ≥2.
- ADDR_W, $clog2(DEPTH): derived index width. Not to be overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  stream data.
- s_valid  in  1  stream beat valid.
- s_last  in  1  final beat of frame; qualified by s_valid && s_ready.
- s_ready  out  1  block accepts a beat this cycle.
- bitrev_mode  in  1  drain order: 0 = natural, 1 = bit-reversed. Sampled on the frame's first accepted beat.
- read  in  1  request the next output word; meaningful only while done = 1.
- dout  out  DATA_WIDTH  output word.
- dout_valid  out  1  dout holds a word, 1-cycle pulse per read.
- done  out  1  a complete frame is held and draining.
- frame_len  out  ADDR_W+1  number of words stored in the current frame (1..DEPTH).
- overflow  out  1  current frame exceeded DEPTH; sticky until the next frame starts.

Behaviour:
- Reset values: state=IDLE; s_ready=0; dout=0; dout_valid=0; done=0; frame_len=0; overflow=0; write and read counters 0. Storage contents are not reset.
- State encoding: IDLE, FILL, DISCARD, DRAIN.
- IDLE:
  - s_ready=1.
  - An accepted beat (s_valid&&s_ready) writes mem[0], latches bitrev_mode, clears overflow and sets wr_cnt=1.
  - With s_last → DRAIN, frame_len=1. Otherwise → FILL.
- FILL:
  - s_ready=1.
  - An accepted beat writes mem[wr_cnt] and increments wr_cnt.
  - With s_last → DRAIN, frame_len=wr_cnt+1.
  - If that beat fills slot DEPTH-1 without s_last → DISCARD, frame_len=DEPTH, overflow=1.
- DISCARD:
  - s_ready=1.
  - Beats are accepted and dropped.
  - An accepted s_last → DRAIN.
- DRAIN:
  - s_ready=0; done=1.
  - The read index is rd_cnt in natural mode, or the ADDR_W-bit reversal of rd_cnt in bitrev mode.
  - Bitrev is honoured only if frame_len==DEPTH. Short frames always drain in natural order.
  - On read: dout <= mem[index] and dout_valid=1 in the following cycle (1-cycle latency), and rd_cnt increments.
  - A read that issues the word at rd_cnt==frame_len-1 is the last read. The next cycle: state → IDLE, done=0, counters cleared, and that final word is presented (dout_valid=1).
- Read behaviour outside DRAIN:
  - read outside DRAIN is ignored; dout_valid stays 0.
  - dout holds its last value when dout_valid=0.
- Back-to-back operation:
  - Reads may be asserted every cycle.
  - Full-frame drain takes frame_len cycles plus 1 cycle of latency.
  - The next frame may be accepted in the cycle after return to IDLE; s_ready rises that cycle.
- Throughput: FILL accepts one beat per cycle with no bubbles.
- Reset mid-frame or mid-drain returns to IDLE next edge. Partial data is abandoned and outputs return to their reset values.
- Counter widths: wr_cnt and rd_cnt are ADDR_W+1 bits. No wrap occurs inside a frame; DISCARD prevents write wrap.

Optional Feature:
- Macro AXIS_FRAME_BUF_LEVEL_EN.
- When defined: adds output port `level` (ADDR_W+1 bits).
  - FILL: level = words stored.
  - DRAIN: level = words remaining (frame_len - rd_cnt).
  - IDLE/reset: level = 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package axis_frame_buffer_pkg holds:
  - the state enum (IDLE, FILL, DISCARD, DRAIN)
  - a parametrised bit-reverse function on ADDR_W bits
- One sub-module, frame_buf_mem: single-write, single-read synchronous-read RAM of DEPTH×DATA_WIDTH, no reset.
- The top level holds the FSM, counters and flags.

Test Plan (DEPTH=8, DATA_WIDTH=32):
- Natural full frame: stream 0x10..0x17 with s_last on 0x17, bitrev_mode=0; read held high → dout 0x10..0x17 in order, 8 dout_valid pulses, frame_len=8, done falls after last.
- Bit-reversed frame: same data with bitrev_mode=1 → dout order 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
- Short frame: 3 beats 0xA0,0xA1,0xA2 with bitrev_mode=1 → frame_len=3, natural order output, overflow=0.
- Overflow: 11 beats 0..10, last on 10 → s_ready stays 1 through beat 10, frame_len=8, overflow=1, dout 0..7.
- Handshake gaps: s_valid toggled randomly during fill, read asserted every third cycle → no lost or duplicated words, s_ready=0 throughout DRAIN, read in IDLE produces no dout_valid.
- Reset mid-drain: assert rst after 4 of 8 reads → next cycle done=0, dout=0, frame_len=0, s_ready=1 one cycle after rst deasserts; a new frame then captures and drains correctly.

Source files
------------

// File: rtl/axis_frame_buffer_pkg.sv
// Shared types and helpers for the AXI-Stream frame buffer.
package axis_frame_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DISCARD,
      DRAIN
   } state_t;

   localparam int unsigned MAX_ADDR_W = 16;

   // Reverses the low `width` bits of v; bits at and above `width` come back as zero.
   function automatic logic [MAX_ADDR_W-1:0] bit_reverse(input logic [MAX_ADDR_W-1:0] v,
                                                         input int                    width);
      logic [MAX_ADDR_W-1:0] r;
      r = '0;
      for (int i = 0; i < width; i++) begin
         r[i] = v[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_buf_mem.sv
// Frame storage: one write port, one synchronous read port whose output holds between reads.
module frame_buf_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // NOTE: the array has no reset so it maps onto block RAM; the top masks rd_data until a real read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_frame_buffer.sv
// Captures one AXI-Stream frame (up to DEPTH words) and drains it on a pull interface.
// Optional `level` output is enabled by defining AXIS_FRAME_BUF_LEVEL_EN.
module axis_frame_buffer
   import axis_frame_buffer_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 16,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   input  logic                  bitrev_mode,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  done,
   output logic [ADDR_W:0]       frame_len,
   output logic                  overflow
`ifdef AXIS_FRAME_BUF_LEVEL_EN
   ,
   output logic [ADDR_W:0]       level
`endif
);

   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_SLOT = DEPTH_CNT - CNT_ONE;

   state_t          state_q, state_d;
   logic            s_ready_q, s_ready_d;
   logic            dout_valid_q, dout_valid_d;
   logic            dout_clr_q, dout_clr_d;
   logic            done_q, done_d;
   logic            overflow_q, overflow_d;
   logic            bitrev_q, bitrev_d;
   logic [ADDR_W:0] frame_len_q, frame_len_d;
   logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_W:0] rd_cnt_q, rd_cnt_d;

   logic                  accept;
   logic                  wr_en, rd_en;
   logic [ADDR_W-1:0]     wr_addr, rd_addr, rd_nat;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign accept = s_valid && s_ready_q;
   assign rd_nat = rd_cnt_q[ADDR_W-1:0];

   // Bit-reversed order only makes sense over the full index space, so short frames stay natural.
   always_comb begin
      rd_addr = rd_nat;
      if (bitrev_q && (frame_len_q == DEPTH_CNT)) begin
         rd_addr = ADDR_W'(bit_reverse(MAX_ADDR_W'(rd_nat), ADDR_W));
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      frame_len_d  = frame_len_q;
      overflow_d   = overflow_q;
      bitrev_d     = bitrev_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      dout_clr_d   = dout_clr_q;
      dout_valid_d = 1'b0;
      wr_en        = 1'b0;
      wr_addr      = wr_cnt_q[ADDR_W-1:0];
      rd_en        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               wr_en      = 1'b1;
               wr_addr    = '0;
               bitrev_d   = bitrev_mode;
               overflow_d = 1'b0;
               wr_cnt_d   = CNT_ONE;
               if (s_last) begin
                  state_d     = DRAIN;
                  frame_len_d = CNT_ONE;
               end else begin
                  state_d     = FILL;
                  frame_len_d = '0;
               end
            end
         end
         FILL: begin
            if (accept) begin
               wr_en    = 1'b1;
               wr_cnt_d = wr_cnt_q + CNT_ONE;
               if (s_last) begin
                  state_d     = DRAIN;
                  frame_len_d = wr_cnt_q + CNT_ONE;
               end else if (wr_cnt_q == LAST_SLOT) begin
                  state_d     = DISCARD;
                  frame_len_d = DEPTH_CNT;
                  overflow_d  = 1'b1;
               end
            end
         end
         DISCARD: begin
            if (accept && s_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (read) begin
               rd_en        = 1'b1;
               dout_valid_d = 1'b1;
               dout_clr_d   = 1'b0;
               rd_cnt_d     = rd_cnt_q + CNT_ONE;
               if (rd_cnt_q == frame_len_q - CNT_ONE) begin
                  state_d  = IDLE;
                  rd_cnt_d = '0;
                  wr_cnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      s_ready_d = (state_d != DRAIN);
      done_d    = (state_d == DRAIN);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         s_ready_q    <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_clr_q   <= 1'b1;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         bitrev_q     <= 1'b0;
         frame_len_q  <= '0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         s_ready_q    <= s_ready_d;
         dout_valid_q <= dout_valid_d;
         dout_clr_q   <= dout_clr_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
         bitrev_q     <= bitrev_d;
         frame_len_q  <= frame_len_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
      end
   end

   frame_buf_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (s_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (mem_rdata)
   );

   assign s_ready    = s_ready_q;
   assign dout       = dout_clr_q ? '0 : mem_rdata;
   assign dout_valid = dout_valid_q;
   assign done       = done_q;
   assign frame_len  = frame_len_q;
   assign overflow   = overflow_q;

`ifdef AXIS_FRAME_BUF_LEVEL_EN
   always_comb begin
      unique case (state_q)
         FILL, DISCARD: level = wr_cnt_q;
         DRAIN:         level = frame_len_q - rd_cnt_q;
         default:       level = '0;
      endcase
   end
`endif

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Directed bench for axis_frame_buffer at DEPTH=8, DATA_WIDTH=32.
module tb_axis_frame_buffer;

   localparam int DW = 32;
   localparam int DP = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_data;
   logic          s_valid, s_last, s_ready;
   logic          bitrev_mode, read;
   logic [DW-1:0] dout;
   logic          dout_valid, done;
   logic [AW:0]   frame_len;
   logic          overflow;
`ifdef AXIS_FRAME_BUF_LEVEL_EN
   logic [AW:0]   level;
`endif

   axis_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .bitrev_mode (bitrev_mode),
      .read        (read),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .done        (done),
      .frame_len   (frame_len),
      .overflow    (overflow)
`ifdef AXIS_FRAME_BUF_LEVEL_EN
      ,
      .level       (level)
`endif
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] tx[$];
   logic [DW-1:0] got[$];
   logic [7:0]    gap_pat = 8'b1001_1011;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives tx[] as one frame; reports whether s_ready was ever low while s_valid was high.
   task automatic send_frame(input bit brev, input bit gappy, output bit stalled);
      int  i = 0;
      int  c = 0;
      bit  go;
      stalled = 1'b0;
      while (i < tx.size() && c < 500) begin
         s_valid     = gappy ? gap_pat[c % 8] : 1'b1;
         s_data      = tx[i];
         s_last      = (i == tx.size() - 1);
         bitrev_mode = brev;
         if (s_valid && !s_ready) stalled = 1'b1;
         go = s_valid && s_ready;
         tick();
         c++;
         if (go) i++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Pulls words while done is high, issuing read every `period` cycles; collects into got[].
   task automatic drain(input int period, output bit sr_high);
      int c = 0;
      got.delete();
      sr_high = 1'b0;
      while (c < 300) begin
         read = ((c % period) == 0) && done;
         tick();
         c++;
         if (dout_valid) got.push_back(dout);
         if (done && s_ready) sr_high = 1'b1;
         if (!done) break;
      end
      read = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (s_ready !== 1'b0)    begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
      total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (dout !== '0)         begin bad++; $display("FAIL rst_dout got=%h exp=0", dout); end
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout_valid got=%b exp=0", dout_valid); end
      total++; if (frame_len !== '0)    begin bad++; $display("FAIL rst_frame_len got=%0d exp=0", frame_len); end
      total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
      rst = 1'b0;
      tick();
      total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL rst_release_s_ready got=%b exp=1", s_ready); end
   endtask

   task automatic test_natural();
      bit st, sr;
      tx = {32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
      send_frame(1'b0, 1'b0, st);
      total++; if (st !== 1'b0)        begin bad++; $display("FAIL nat_stall got=%b exp=0", st); end
      total++; if (done !== 1'b1)      begin bad++; $display("FAIL nat_done got=%b exp=1", done); end
      total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL nat_s_ready got=%b exp=0", s_ready); end
      total++; if (frame_len !== 4'd8) begin bad++; $display("FAIL nat_frame_len got=%0d exp=8", frame_len); end
      drain(1, sr);
      total++; if (got.size() !== 8)   begin bad++; $display("FAIL nat_count got=%0d exp=8", got.size()); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (k >= got.size() || got[k] !== tx[k]) begin
            bad++; $display("FAIL nat_word[%0d] got=%h exp=%h", k, got[k], tx[k]);
         end
      end
      total++; if (sr !== 1'b0)        begin bad++; $display("FAIL nat_s_ready_in_drain got=%b exp=0", sr); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL nat_done_fall got=%b exp=0", done); end
      tick();
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL nat_valid_after got=%b exp=0", dout_valid); end
   endtask

   task automatic test_bitrev();
      bit st, sr;
      logic [DW-1:0] exp_q[$];
      exp_q = {32'h10, 32'h14, 32'h12, 32'h16, 32'h11, 32'h15, 32'h13, 32'h17};
      tx    = {32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
      send_frame(1'b1, 1'b0, st);
      total++; if (frame_len !== 4'd8) begin bad++; $display("FAIL brev_frame_len got=%0d exp=8", frame_len); end
      drain(1, sr);
      total++; if (got.size() !== 8)   begin bad++; $display("FAIL brev_count got=%0d exp=8", got.size()); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (k >= got.size() || got[k] !== exp_q[k]) begin
            bad++; $display("FAIL brev_word[%0d] got=%h exp=%h", k, got[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_short();
      bit st, sr;
      tx = {32'hA0, 32'hA1, 32'hA2};
      send_frame(1'b1, 1'b0, st);
      total++; if (frame_len !== 4'd3) begin bad++; $display("FAIL short_frame_len got=%0d exp=3", frame_len); end
      total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL short_overflow got=%b exp=0", overflow); end
      drain(1, sr);
      total++; if (got.size() !== 3)   begin bad++; $display("FAIL short_count got=%0d exp=3", got.size()); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (k >= got.size() || got[k] !== tx[k]) begin
            bad++; $display("FAIL short_word[%0d] got=%h exp=%h", k, got[k], tx[k]);
         end
      end
   endtask

   task automatic test_overflow();
      bit st, sr;
      tx.delete();
      for (int k = 0; k <= 10; k++) tx.push_back(DW'(k));
      send_frame(1'b0, 1'b0, st);
      total++; if (st !== 1'b0)        begin bad++; $display("FAIL ovf_s_ready_drop got=%b exp=0", st); end
      total++; if (frame_len !== 4'd8) begin bad++; $display("FAIL ovf_frame_len got=%0d exp=8", frame_len); end
      total++; if (overflow !== 1'b1)  begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      total++; if (done !== 1'b1)      begin bad++; $display("FAIL ovf_done got=%b exp=1", done); end
      drain(1, sr);
      total++; if (got.size() !== 8)   begin bad++; $display("FAIL ovf_count got=%0d exp=8", got.size()); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (k >= got.size() || got[k] !== DW'(k)) begin
            bad++; $display("FAIL ovf_word[%0d] got=%h exp=%h", k, got[k], k);
         end
      end
   endtask

   task automatic test_gaps();
      bit st, sr;
      tx = {32'h50, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56, 32'h57};
      send_frame(1'b0, 1'b1, st);
      total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL gap_overflow_clear got=%b exp=0", overflow); end
      total++; if (frame_len !== 4'd8) begin bad++; $display("FAIL gap_frame_len got=%0d exp=8", frame_len); end
      drain(3, sr);
      total++; if (sr !== 1'b0)        begin bad++; $display("FAIL gap_s_ready_in_drain got=%b exp=0", sr); end
      total++; if (got.size() !== 8)   begin bad++; $display("FAIL gap_count got=%0d exp=8", got.size()); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (k >= got.size() || got[k] !== tx[k]) begin
            bad++; $display("FAIL gap_word[%0d] got=%h exp=%h", k, got[k], tx[k]);
         end
      end
      read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL idle_read_valid got=%b exp=0", dout_valid); end
         total++; if (dout !== 32'h57)     begin bad++; $display("FAIL idle_dout_hold got=%h exp=57", dout); end
      end
      read = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      bit st, sr;
      tx = {32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27};
      send_frame(1'b0, 1'b0, st);
      read = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      total++; if (dout !== 32'h23)     begin bad++; $display("FAIL mid_fourth_word got=%h exp=23", dout); end
      read = 1'b0;
      rst  = 1'b1;
      tick();
      total++; if (done !== 1'b0)       begin bad++; $display("FAIL mid_rst_done got=%b exp=0", done); end
      total++; if (dout !== '0)         begin bad++; $display("FAIL mid_rst_dout got=%h exp=0", dout); end
      total++; if (frame_len !== '0)    begin bad++; $display("FAIL mid_rst_frame_len got=%0d exp=0", frame_len); end
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", dout_valid); end
      rst = 1'b0;
      tick();
      total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL mid_rst_s_ready got=%b exp=1", s_ready); end
      tx = {32'h30, 32'h31, 32'h32};
      send_frame(1'b0, 1'b0, st);
      total++; if (frame_len !== 4'd3)  begin bad++; $display("FAIL mid_new_frame_len got=%0d exp=3", frame_len); end
      drain(1, sr);
      total++; if (got.size() !== 3)    begin bad++; $display("FAIL mid_new_count got=%0d exp=3", got.size()); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (k >= got.size() || got[k] !== tx[k]) begin
            bad++; $display("FAIL mid_new_word[%0d] got=%h exp=%h", k, got[k], tx[k]);
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      s_data      = '0;
      s_valid     = 1'b0;
      s_last      = 1'b0;
      bitrev_mode = 1'b0;
      read        = 1'b0;
      test_reset();
      test_natural();
      test_bitrev();
      test_short();
      test_overflow();
      test_gaps();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
